// File: rtl/mult_serial_seq_if.sv
// Operand/product handshake plus the serial link to a bit-serial shift-add multiplier core.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface mult_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic [WIDTH-1:0]     ser_mcand;
  logic                 ser_bit;
  logic                 ser_en;
  logic                 ser_clr;
  logic                 prod_bit;
  logic                 busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, prod_bit,
    output in_ready, out_valid, out_prod, ser_mcand, ser_bit, ser_en, ser_clr, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, prod_bit,
    input  in_ready, out_valid, out_prod, ser_mcand, ser_bit, ser_en, ser_clr, busy
  );
endinterface

// File: rtl/mult_serial_seq.sv
// Sequencer/collector for a bit-serial multiplier core: clear, stream b LSB-first, flush with
// zeros, and assemble the 2*WIDTH-bit product from the core's serial output.
module mult_serial_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  mult_serial_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    FLUSH,
    DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    prod_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             ser_en_q;
  logic             ser_clr_q;
  logic             busy_q;

  logic             last_count;
  assign last_count = (count_q == CNT_W'(WIDTH - 1));

  // b_q shifts right once per SHIFT cycle, so its LSB is the current multiplier bit and it
  // drains to zero before FLUSH; a_q doubles as the multiplicand bus and is zeroed outside use.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset too, so nothing stale ever reaches the core or consumer.
      state_q     <= IDLE;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ser_en_q    <= 1'b0;
      ser_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            ser_clr_q  <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CLEAR;
          end
        end
        CLEAR: begin
          ser_clr_q <= 1'b0;
          ser_en_q  <= 1'b1;
          count_q   <= '0;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          prod_q <= {bus.prod_bit, prod_q[PW-1:1]};
          b_q    <= b_q >> 1;
          if (last_count) begin
            count_q <= '0;
            state_q <= FLUSH;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        FLUSH: begin
          prod_q <= {bus.prod_bit, prod_q[PW-1:1]};
          if (last_count) begin
            count_q     <= '0;
            a_q         <= '0;
            ser_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = prod_q;
  assign bus.ser_mcand = a_q;
  assign bus.ser_bit   = b_q[0];
  assign bus.ser_en    = ser_en_q;
  assign bus.ser_clr   = ser_clr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_serial_seq.sv
// Bench for mult_serial_seq with a behavioural shift-add core on the serial link and a
// scoreboard monitor that checks every delivered product against directed expectations.
module tb_mult_serial_seq;

  localparam int W = 16;

  logic clock;
  logic reset_n;

  mult_serial_seq_if #(.WIDTH(W)) bus ();

  mult_serial_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural serial core: the product bit is combinational on the current ser_bit.
  logic [W:0] core_acc;
  logic [W:0] core_sum;
  assign core_sum     = core_acc + (bus.ser_bit ? {1'b0, bus.ser_mcand} : {(W+1){1'b0}});
  assign bus.prod_bit = core_sum[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        core_acc <= '0;
    else if (bus.ser_clr) core_acc <= '0;
    else if (bus.ser_en)  core_acc <= core_sum >> 1;
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and observation state shared with the monitor.
  logic [2*W-1:0] exp_q[$];
  int             acc_edges[$];
  int             edge_cnt = 0;
  int             last_acc = 0;
  int             last_out = 0;
  int             clr_cnt  = 0;
  int             en_cnt   = 0;
  logic [31:0]    bit_log;
  logic           prev_ov  = 1'b0;

  initial begin
    forever begin
      @(posedge clock);
      edge_cnt++;
    end
  end

  // Monitor samples at the falling edge; edge_cnt there is the index of the upcoming rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          last_acc = edge_cnt;
          acc_edges.push_back(edge_cnt);
        end
        if (bus.ser_clr) clr_cnt++;
        if (bus.ser_en) begin
          if (en_cnt < 32) bit_log[en_cnt] = bus.ser_bit;
          en_cnt++;
        end
        if (bus.out_valid && !prev_ov) check("latency", 64'(edge_cnt - last_acc), 64'd34);
        if (bus.out_valid && bus.out_ready) begin
          last_out = edge_cnt;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_product: got 0x%0h with empty scoreboard", bus.out_prod);
          end else begin
            check("product", 64'(bus.out_prod), 64'(exp_q.pop_front()));
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  // Present a pair and hold in_valid until the accept edge; afterwards the inputs are scrambled
  // to show that post-accept changes have no effect.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [2*W-1:0] exp);
    bit ok;
    if (push) exp_q.push_back(exp);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready never rose for a=0x%0h b=0x%0h", a, b);
    end
    @(posedge clock);
    #1;
    bus.in_a = ~a;
    bus.in_b = 16'h5A5A;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL result_timeout: %0d products still pending", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    clr_cnt = 0;
    en_cnt  = 0;
    bit_log = '0;
  endtask

  initial begin
    bit ok;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_ser_en",    64'(bus.ser_en),    64'd0);
    check("rst_ser_clr",   64'(bus.ser_clr),   64'd0);
    check("rst_ser_bit",   64'(bus.ser_bit),   64'd0);
    check("rst_ser_mcand", 64'(bus.ser_mcand), 64'd0);
    check("rst_out_prod",  64'(bus.out_prod),  64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic product with pulse/enable accounting.
    clear_counts();
    drive(16'd3, 16'd5, 1'b1, 32'h0000_000F);
    bus.in_valid = 1'b0;
    wait_done();
    check("basic_clr_pulses", 64'(clr_cnt), 64'd1);
    check("basic_en_cycles",  64'(en_cnt),  64'd32);
    check("idle_ser_mcand",   64'(bus.ser_mcand), 64'd0);
    check("idle_ser_bit",     64'(bus.ser_bit),   64'd0);

    // Full-scale operands.
    drive(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);
    bus.in_valid = 1'b0;
    wait_done();

    // Zero operands; the serial stream must be b LSB-first followed by zero flush bits.
    clear_counts();
    drive(16'h0000, 16'hABCD, 1'b1, 32'h0);
    bus.in_valid = 1'b0;
    wait_done();
    check("ser_bit_stream", 64'(bit_log), 64'h0000_ABCD);
    drive(16'h1234, 16'h0000, 1'b1, 32'h0);
    bus.in_valid = 1'b0;
    wait_done();

    // Backpressure in DONE with the next pair already waiting on in_valid.
    bus.out_ready = 1'b0;
    drive(16'd7, 16'd9, 1'b1, 32'd63);
    exp_q.push_back(32'd143);
    bus.in_a     = 16'd11;
    bus.in_b     = 16'd13;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_reached_done", 64'(ok), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_prod_stable", 64'(bus.out_prod),  64'd63);
      check("bp_in_ready",    64'(bus.in_ready),  64'd0);
      check("bp_out_valid",   64'(bus.out_valid), 64'd1);
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_next_accepted", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    check("bp_return_gap", 64'(last_acc - last_out), 64'd1);
    wait_done();

    // Mid-operation reset during SHIFT with count=7; the aborted product is never expected.
    drive(16'h5555, 16'h3333, 1'b0, 32'h0);
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("pre_rst_ser_en", 64'(bus.ser_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ser_en",    64'(bus.ser_en),    64'd0);
    check("mid_rst_busy",      64'(bus.busy),      64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(16'h00FF, 16'h0101, 1'b1, 32'h0000_FFFF);
    bus.in_valid = 1'b0;
    wait_done();

    // Back-to-back with in_valid and out_ready held high.
    acc_edges.delete();
    bus.out_ready = 1'b1;
    drive(16'd2,      16'd3,      1'b1, 32'd6);
    drive(16'h8000,   16'd2,      1'b1, 32'h0001_0000);
    drive(16'h1111,   16'h000F,   1'b1, 32'h0000_FFFF);
    bus.in_valid = 1'b0;
    wait_done();
    check("b2b_accepts", 64'(acc_edges.size()), 64'd3);
    if (acc_edges.size() == 3) begin
      check("b2b_gap_1", 64'(acc_edges[1] - acc_edges[0]), 64'd35);
      check("b2b_gap_2", 64'(acc_edges[2] - acc_edges[1]), 64'd35);
    end

    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
